// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Qualifies an asynchronous PLL lock flag and sequences a clean
//               active-high reset for one PLL output clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  soft_reset,
    output logic                  rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int C_MAX   = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int C_CNT_W = (C_MAX > 1) ? $clog2(C_MAX) : 1;
    localparam logic [C_CNT_W-1:0] C_STABLE_LAST = C_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST   = C_CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABILIZE = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [C_CNT_W-1:0]     w_cnt_nxt;
    logic                   r_lock_lost;
    logic                   w_lock_lost_nxt;
    logic [LOSS_CNT_W-1:0]  r_loss_cnt;
    logic [LOSS_CNT_W-1:0]  w_loss_cnt_nxt;
    logic                   w_locked_s;

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync      <= '0;
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_loss_cnt  <= w_loss_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lock_lost_nxt = 1'b0;
        w_loss_cnt_nxt  = r_loss_cnt;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABILIZE;
                    w_cnt_nxt   = '0;
                end
            end
            S_STABILIZE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Lock loss takes priority over a coincident soft reset request
                if (!w_locked_s) begin
                    w_state_nxt     = S_WAIT_LOCK;
                    w_cnt_nxt       = '0;
                    w_lock_lost_nxt = 1'b1;
                    if (r_loss_cnt != {LOSS_CNT_W{1'b1}}) begin
                        w_loss_cnt_nxt = r_loss_cnt + 1'b1;
                    end
                end else if (soft_reset) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rst_out         = (r_state != S_RUN);
    assign ready           = (r_state == S_RUN);
    assign lock_lost       = r_lock_lost;
    assign lock_loss_count = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed and randomized bench for pll_reset_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int RHC  = 4;
    localparam int LCW  = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           pll_locked = 1'b0;
    logic           soft_reset = 1'b0;
    logic           rst_out;
    logic           ready;
    logic           lock_lost;
    logic [LCW-1:0] lock_loss_count;

    int tests = 0;
    int fails = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .RESET_HOLD_CYCLES  (RHC),
        .LOSS_CNT_W         (LCW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .soft_reset      (soft_reset),
        .rst_out         (rst_out),
        .ready           (ready),
        .lock_lost       (lock_lost),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clock = ~clock;

    // Model: lock flag seen through a SYNC-edge delay line; "remaining" counts
    // edges still needed before the domain is released (-1 = not qualifying).
    bit m_q[$];
    bit m_run  = 1'b0;
    int m_rem  = -1;
    bit m_lost = 1'b0;
    int m_cnt  = 0;

    task automatic model_edge();
        bit ls;
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
            m_run = 1'b0; m_rem = -1; m_lost = 1'b0; m_cnt = 0;
            return;
        end
        ls = m_q[0];
        m_lost = 1'b0;
        if (!ls) begin
            if (m_run) begin
                m_lost = 1'b1;
                if (m_cnt < (1 << LCW) - 1) m_cnt++;
            end
            m_run = 1'b0;
            m_rem = -1;
        end else if (m_run) begin
            if (soft_reset) begin
                m_run = 1'b0;
                m_rem = RHC;
            end
        end else begin
            if (m_rem < 0) m_rem = LSC + RHC + 1;
            m_rem--;
            if (m_rem == 0) m_run = 1'b1;
        end
        void'(m_q.pop_front());
        m_q.push_back(pll_locked);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        chk("rst_out", 32'(rst_out), 32'(!m_run));
        chk("ready", 32'(ready), 32'(m_run));
        chk("lock_lost", 32'(lock_lost), 32'(m_lost));
        chk("loss_count", 32'(lock_loss_count), 32'(m_cnt));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        int n;
        int hold;
        logic [LCW-1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state, then rising-lock latency (release after edge 15)
        step(); step();
        chk("reset_rst_out", 32'(rst_out), 32'd1);
        chk("reset_ready", 32'(ready), 32'd0);
        pll_locked = 1'b1;
        reset = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            step();
            chk("t1_rst_out_edge", 32'(rst_out), (e < 15) ? 32'd1 : 32'd0);
        end

        // Dropout while qualifying restarts qualification without a pulse
        reset = 1'b1; step(); reset = 1'b0;
        repeat (SYNC + 1 + 5) step();
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        repeat (30) step();
        chk("t2_count", 32'(lock_loss_count), 32'd0);

        // Lock loss from RUN: pulse after edge k+2, gone after k+3
        pll_locked = 1'b0;
        step(); step();
        chk("t3_lost_early", 32'(lock_lost), 32'd0);
        step();
        chk("t3_lost", 32'(lock_lost), 32'd1);
        chk("t3_rst", 32'(rst_out), 32'd1);
        step();
        chk("t3_lost_clear", 32'(lock_lost), 32'd0);
        chk("t3_count", 32'(lock_loss_count), 32'd1);

        // Soft reset from RUN holds reset for exactly RHC cycles
        pll_locked = 1'b1;
        wait_ready("t4_ready");
        soft_reset = 1'b1; step(); soft_reset = 1'b0;
        n = rst_out ? 1 : 0;
        hold = 0;
        while (!ready && hold < 20) begin
            step();
            hold++;
            if (rst_out) n++;
        end
        chk("t4_hold_len", 32'(n), 32'(RHC));
        chk("t4_count", 32'(lock_loss_count), 32'd1);
        // Soft reset in WAIT_LOCK is ignored
        pll_locked = 1'b0;
        repeat (4) step();
        soft_reset = 1'b1; step(); soft_reset = 1'b0;
        repeat (3) step();

        // Coincident lock loss and soft reset: loss wins
        pll_locked = 1'b1;
        wait_ready("t5_ready");
        pll_locked = 1'b0;
        step(); step();
        soft_reset = 1'b1; step(); soft_reset = 1'b0;
        chk("t5_lost", 32'(lock_lost), 32'd1);
        chk("t5_count", 32'(lock_loss_count), 32'd3);

        // Saturating loss counter, then reset mid-HOLD clears everything
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b1;
            wait_ready("t6_ready");
            pll_locked = 1'b0;
            repeat (SYNC + 1) step();
            chk("t6_sat", 32'(lock_loss_count), 32'(exp_cnt[i]));
        end
        pll_locked = 1'b1;
        repeat (SYNC + 1 + LSC + 2) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_rst_count", 32'(lock_loss_count), 32'd0);
        chk("t6_rst_out", 32'(rst_out), 32'd1);

        // Randomized lock dropouts and soft resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) pll_locked = ~pll_locked;
            soft_reset = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
            if (!pll_locked && $urandom_range(0, 3) == 0) pll_locked = 1'b1;
        end
        soft_reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
